// File: rtl/hfast_cache256.sv
// hfast_cache256: direct-mapped write-through read-allocate cache, 256-bit lines, HFAST1 on both sides.
// Optional hit/miss counters are enabled with CACHE_STATS_EN.
module hfast_cache256 #(
  parameter int DWIDTH  = 256,
  parameter int LANES   = 32,
  parameter int AWIDTH  = 22,
  parameter int IDXBITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fs_rwbar,
  input  logic [AWIDTH-1:0] fs_addr,
  input  logic [DWIDTH-1:0] fs_wdata,
  input  logic [LANES-1:0]  fs_lanes,
  input  logic              fs_opreq,
  output logic              fs_oprdy,
  output logic              fs_ack,
  output logic [DWIDTH-1:0] fs_rdata,
  output logic              bs_rwbar,
  output logic [AWIDTH-1:0] bs_addr,
  output logic [DWIDTH-1:0] bs_wdata,
  output logic [LANES-1:0]  bs_lanes,
  output logic              bs_opreq,
  input  logic              bs_oprdy,
  input  logic              bs_ack,
  input  logic [DWIDTH-1:0] bs_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);
  localparam int TW = AWIDTH - IDXBITS;
  localparam int NLINES = 2 ** IDXBITS;

  typedef enum logic [2:0] {IDLE, FILL_REQ, FILL_WAIT, WR_REQ, WR_WAIT} state_t;

  state_t              state;
  logic [DWIDTH-1:0]   data_ram [NLINES];
  logic [TW-1:0]       tag_ram [NLINES];
  logic [NLINES-1:0]   valid;
  logic [IDXBITS-1:0]  idx;
  logic [IDXBITS-1:0]  lidx;
  logic [TW-1:0]       tag;
  logic                acc;
  logic                hit;
  logic                fill_we;
  logic                wr_we;

  // The pending back-side address doubles as the latched request address.
  assign idx     = fs_addr[IDXBITS-1:0];
  assign tag     = fs_addr[AWIDTH-1:IDXBITS];
  assign lidx    = bs_addr[IDXBITS-1:0];
  assign acc     = fs_opreq && fs_oprdy;
  assign hit     = valid[idx] && (tag_ram[idx] == tag);
  assign fill_we = (state == FILL_WAIT) && bs_ack;
  assign wr_we   = acc && !fs_rwbar && hit;

  // Tag/data RAMs: line fill on back-side read completion, byte-lane merge on an accepted write hit.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_ram[lidx] <= bs_rdata;
      tag_ram[lidx]  <= bs_addr[AWIDTH-1:IDXBITS];
    end else if (wr_we) begin
      for (int i = 0; i < LANES; i++)
        if (fs_lanes[i]) data_ram[idx][i*8 +: 8] <= fs_wdata[i*8 +: 8];
    end
  end

  // Control FSM with registered handshake outputs on both sides.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      valid    <= '0;
      fs_oprdy <= 1'b0;
      fs_ack   <= 1'b0;
      fs_rdata <= '0;
      bs_opreq <= 1'b0;
      bs_rwbar <= 1'b1;
      bs_addr  <= '0;
      bs_wdata <= '0;
      bs_lanes <= '0;
    end else begin
      fs_ack <= 1'b0;
      case (state)
        IDLE: begin
          fs_oprdy <= 1'b1;
          if (acc) begin
            if (fs_rwbar && hit) begin
              fs_rdata <= data_ram[idx];
              fs_ack   <= 1'b1;
            end else begin
              fs_oprdy <= 1'b0;
              bs_opreq <= 1'b1;
              bs_rwbar <= fs_rwbar;
              bs_addr  <= fs_addr;
              bs_wdata <= fs_wdata;
              bs_lanes <= fs_rwbar ? '1 : fs_lanes;
              state    <= fs_rwbar ? FILL_REQ : WR_REQ;
            end
          end
        end
        FILL_REQ, WR_REQ: begin
          if (bs_oprdy) begin
            bs_opreq <= 1'b0;
            state    <= (state == FILL_REQ) ? FILL_WAIT : WR_WAIT;
          end
        end
        FILL_WAIT: begin
          if (bs_ack) begin
            valid[lidx] <= 1'b1;
            fs_rdata    <= bs_rdata;
            fs_ack      <= 1'b1;
            fs_oprdy    <= 1'b1;
            state       <= IDLE;
          end
        end
        WR_WAIT: begin
          if (bs_ack) begin
            fs_ack   <= 1'b1;
            fs_oprdy <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Read hit/miss counters, counted at front-side acceptance; writes are not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (acc && fs_rwbar) begin
      if (hit) stat_hits <= stat_hits + 32'd1;
      else stat_misses <= stat_misses + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hfast_cache256.sv
// tb_hfast_cache256: randomized self-checking bench with a memory-level reference model and a DRAM responder.
module tb_hfast_cache256;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         fs_rwbar = 1'b1;
  logic [21:0]  fs_addr = '0;
  logic [255:0] fs_wdata = '0;
  logic [31:0]  fs_lanes = '0;
  logic         fs_opreq = 1'b0;
  logic         fs_oprdy;
  logic         fs_ack;
  logic [255:0] fs_rdata;
  logic         bs_rwbar;
  logic [21:0]  bs_addr;
  logic [255:0] bs_wdata;
  logic [31:0]  bs_lanes;
  logic         bs_opreq;
  logic         bs_oprdy = 1'b0;
  logic         bs_ack = 1'b0;
  logic [255:0] bs_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [31:0]  stat_hits;
  logic [31:0]  stat_misses;
`endif

  hfast_cache256 dut (
    .clk(clk), .reset(reset),
    .fs_rwbar(fs_rwbar), .fs_addr(fs_addr), .fs_wdata(fs_wdata), .fs_lanes(fs_lanes),
    .fs_opreq(fs_opreq), .fs_oprdy(fs_oprdy), .fs_ack(fs_ack), .fs_rdata(fs_rdata),
    .bs_rwbar(bs_rwbar), .bs_addr(bs_addr), .bs_wdata(bs_wdata), .bs_lanes(bs_lanes),
    .bs_opreq(bs_opreq), .bs_oprdy(bs_oprdy), .bs_ack(bs_ack), .bs_rdata(bs_rdata)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int bs_reads = 0;
  int bs_writes = 0;
  int m_hits = 0;
  int m_misses = 0;

  logic [255:0] ref_mem [logic [21:0]];
  logic [255:0] dram [logic [21:0]];
  bit   [255:0] mvalid;
  logic [13:0]  mtag [256];
  logic [255:0] last_rdata = '0;
  logic [21:0]  exp_addr;
  logic [255:0] exp_wdata;
  logic [31:0]  exp_lanes;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input logic [21:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = {a, k[9:0]} * 32'h9E3779B1 + 32'h1234;
    return l;
  endfunction

  function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] wd, input logic [31:0] ln);
    logic [255:0] l = old;
    for (int i = 0; i < 32; i++) if (ln[i]) l[i*8 +: 8] = wd[i*8 +: 8];
    return l;
  endfunction

  function automatic logic [255:0] ref_get(input logic [21:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  function automatic logic [255:0] dram_get(input logic [21:0] a);
    return dram.exists(a) ? dram[a] : init_line(a);
  endfunction

  // DRAM controller model: random ready and ack latencies, checks request fields.
  initial begin
    forever begin
      @(negedge clk);
      bs_oprdy = 1'b0;
      bs_ack = 1'b0;
      if (bs_opreq) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bs_oprdy = 1'b1;
        chk("bs_addr", bs_addr, exp_addr);
        if (bs_rwbar) chk("bs_fill_lanes", bs_lanes, 32'hFFFF_FFFF);
        else begin
          chk("bs_wr_lanes", bs_lanes, exp_lanes);
          chk("bs_wr_data", bs_wdata, exp_wdata);
        end
        @(negedge clk);
        bs_oprdy = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (bs_rwbar) begin
          bs_rdata = dram_get(bs_addr);
          bs_reads++;
        end else begin
          dram[bs_addr] = merge(dram_get(bs_addr), bs_wdata, bs_lanes);
          bs_writes++;
        end
        bs_ack = 1'b1;
      end
    end
  end

  task automatic do_req(input logic rw, input logic [21:0] a, input logic [255:0] wd, input logic [31:0] ln);
    int rd0 = bs_reads;
    int wr0 = bs_writes;
    int n = 0;
    bit hit = rw && mvalid[a[7:0]] && (mtag[a[7:0]] == a[21:8]);
    exp_addr = a;
    exp_wdata = wd;
    exp_lanes = ln;
    @(negedge clk);
    fs_rwbar = rw;
    fs_addr = a;
    fs_wdata = wd;
    fs_lanes = ln;
    fs_opreq = 1'b1;
    while (!fs_oprdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("accept_timeout", 1'b0, 1'b1);
      fs_opreq = 1'b0;
      return;
    end
    @(posedge clk);
    #1 fs_opreq = 1'b0;
    if (rw) begin
      if (hit) m_hits++;
      else begin
        m_misses++;
        mvalid[a[7:0]] = 1'b1;
        mtag[a[7:0]] = a[21:8];
      end
    end else ref_mem[a] = merge(ref_get(a), wd, ln);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs_ack && n < 100);
    chk("ack_seen", fs_ack, 1'b1);
    if (rw) begin
      chk("rdata", fs_rdata, ref_get(a));
      if (hit) chk("hit_latency", n, 1);
      last_rdata = fs_rdata;
    end else chk("wr_rdata_hold", fs_rdata, last_rdata);
    @(negedge clk);
    chk("ack_pulse", fs_ack, 1'b0);
    chk("bs_reads", bs_reads - rd0, (rw && !hit) ? 1 : 0);
    chk("bs_writes", bs_writes - wr0, rw ? 0 : 1);
  endtask

  task automatic check_stats();
`ifdef CACHE_STATS_EN
    chk("stat_hits", stat_hits, m_hits);
    chk("stat_misses", stat_misses, m_misses);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] b2b [4];
    logic [255:0] p;
    int n;
    bit ack_any;
    mvalid = '0;
    repeat (3) @(negedge clk);
    chk("rst_oprdy", fs_oprdy, 1'b0);
    chk("rst_ack", fs_ack, 1'b0);
    chk("rst_rdata", fs_rdata, 256'd0);
    chk("rst_bs_opreq", bs_opreq, 1'b0);
    chk("rst_bs_rwbar", bs_rwbar, 1'b1);
    chk("rst_bs_addr", bs_addr, 22'd0);
    chk("rst_bs_wdata", bs_wdata, 256'd0);
    chk("rst_bs_lanes", bs_lanes, 32'd0);
    check_stats();
    reset = 1'b1;

    do_req(1'b1, 22'h000010, '0, '0);
    do_req(1'b1, 22'h000010, '0, '0);
    do_req(1'b1, 22'h000011, '0, '0);
    do_req(1'b1, 22'h000012, '0, '0);

    b2b = '{22'h000010, 22'h000011, 22'h000012, 22'h000010};
    n = bs_reads;
    @(negedge clk);
    fs_rwbar = 1'b1;
    fs_addr = b2b[0];
    fs_opreq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) fs_addr = b2b[i+1];
      else fs_opreq = 1'b0;
      m_hits++;
      @(negedge clk);
      chk("b2b_ack", fs_ack, 1'b1);
      chk("b2b_rdata", fs_rdata, ref_get(b2b[i]));
    end
    last_rdata = fs_rdata;
    chk("b2b_no_bs", bs_reads - n, 0);

    p = ref_get(22'h000010);
    do_req(1'b0, 22'h000010, 256'hAB, 32'h1);
    do_req(1'b1, 22'h000010, '0, '0);
    chk("wr_hit_merge", last_rdata, {p[255:8], 8'hAB});
    do_req(1'b0, 22'h000011, {8{32'hDEAD_BEEF}}, 32'h0);
    do_req(1'b1, 22'h000011, '0, '0);
    do_req(1'b1, 22'h000110, '0, '0);
    do_req(1'b1, 22'h000010, '0, '0);
    do_req(1'b0, 22'h000020, {8{32'h5555_AAAA}}, 32'hFFFF_FFFF);
    do_req(1'b1, 22'h000020, '0, '0);
    check_stats();

    exp_addr = 22'h000210;
    @(negedge clk);
    fs_rwbar = 1'b1;
    fs_addr = 22'h000210;
    fs_opreq = 1'b1;
    n = 0;
    while (!fs_oprdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 fs_opreq = 1'b0;
    n = 0;
    while (!bs_opreq && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (bs_opreq && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("fill_wait_reached", n < 100, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_oprdy", fs_oprdy, 1'b0);
    chk("mid_rst_bs_opreq", bs_opreq, 1'b0);
    mvalid = '0;
    m_hits = 0;
    m_misses = 0;
    last_rdata = '0;
    ack_any = 1'b0;
    repeat (6) begin
      @(negedge clk);
      ack_any |= fs_ack;
    end
    reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      ack_any |= fs_ack;
    end
    chk("no_ack_after_reset", ack_any, 1'b0);
    do_req(1'b1, 22'h000010, '0, '0);
    check_stats();

    for (int t = 0; t < 150; t++) begin
      logic [21:0] a;
      logic [31:0] ln;
      logic [255:0] wd;
      a = {12'd0, 2'($urandom_range(0, 2)), 8'h10 + 8'($urandom_range(0, 2))};
      for (int k = 0; k < 8; k++) wd[k*32 +: 32] = $urandom;
      case ($urandom_range(0, 3))
        0: ln = 32'h0;
        1: ln = 32'hFFFF_FFFF;
        default: ln = $urandom;
      endcase
      do_req($urandom_range(0, 2) != 0, a, wd, ln);
    end
    check_stats();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/hfast_cache256.md
Name: hfast_cache256

Overview:
- Direct-mapped, write-through, read-allocate cache with 256-bit lines.
- Sits between a Kiwi-generated load/store port (front side, HFAST1 protocol) and an off-chip DRAM controller (back side, same HFAST1 signature).
- Because both sides share the same signature, the cache can be inserted or removed without touching either neighbour.
- Supports bytelane writes and back-to-back read hits.

Parameters:
- DWIDTH, 256, line/data width in bits.
- LANES, 32, byte lanes (DWIDTH/8).
- AWIDTH, 22, line (word) address width.
- IDXBITS, 8, index bits; 256 lines; tag = AWIDTH-IDXBITS = 14 bits.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fs_rwbar  in  1  front request: 1=read, 0=write.
- fs_addr  in  22  front line address.
- fs_wdata  in  256  front write data.
- fs_lanes  in  32  front byte-lane write enables.
- fs_opreq  in  1  front request valid.
- fs_oprdy  out  1  cache can accept a request.
- fs_ack  out  1  one-cycle completion pulse.
- fs_rdata  out  256  read data, valid while fs_ack=1.
- bs_rwbar  out  1  back request: 1=read, 0=write.
- bs_addr  out  22  back address.
- bs_wdata  out  256  back write data.
- bs_lanes  out  32  back lanes.
- bs_opreq  out  1  back request valid.
- bs_oprdy  in  1  controller ready.
- bs_ack  in  1  controller completion pulse (read data valid on bs_rdata).
- bs_rdata  in  256  back read data.

Behaviour:
- Handshake (both sides): a transfer is accepted in the cycle opreq=1 and oprdy=1. The responder pulses ack for exactly one cycle per accepted transfer.
- Reset (reset=0, async):
  - All 256 valid bits cleared; state=IDLE.
  - fs_oprdy=0, fs_ack=0, fs_rdata=0.
  - bs_opreq=0, bs_rwbar=1, bs_addr=0, bs_wdata=0, bs_lanes=0.
  - Tag and data RAMs are not reset.
  - Reset mid-transaction abandons it; no fs_ack is issued.
- Address split: idx=fs_addr[7:0], tag=fs_addr[21:8].
- IDLE:
  - fs_oprdy=1.
  - Read hit accepted (valid[idx] and tag match): fs_rdata=line, fs_ack=1 on the next cycle; remain IDLE. A new request may be accepted in that same ack cycle (1 hit/cycle throughput).
  - Read miss accepted: latch request → FILL_REQ.
  - Write accepted (hit or miss): latch request → WR_REQ.
- FILL_REQ:
  - fs_oprdy=0; bs_opreq=1, bs_rwbar=1, bs_addr=latched addr, bs_lanes=all ones.
  - On bs_oprdy=1 → FILL_WAIT (bs_opreq drops the following cycle).
- FILL_WAIT:
  - On bs_ack: write bs_rdata into data[idx], tag[idx]=tag, valid[idx]=1.
  - Next cycle: fs_rdata=bs_rdata, fs_ack=1; → IDLE.
- WR_REQ:
  - bs_opreq=1, bs_rwbar=0; bs_addr/bs_wdata/bs_lanes = latched values.
  - On acceptance → WR_WAIT.
- WR_WAIT:
  - On bs_ack: fs_ack=1 on the next cycle; → IDLE.
  - Write hit: for each lane i with lanes[i]=1, byte i of the cached line is replaced. The update happens at acceptance, so a read of the same line issued after fs_ack returns the new data.
  - Write miss: no allocation.
- fs_ack=1 with fs_rwbar=0 carries no meaningful fs_rdata; fs_rdata holds its previous value.
- fs_opreq while fs_oprdy=0 is ignored. The requester must hold the request until accepted.
- bs_ack outside FILL_WAIT/WR_WAIT is ignored.
- A write with fs_lanes=0 still goes through the back-side write and acks; it has no data effect.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: extra output ports stat_hits[31:0] and stat_misses[31:0], both reset to 0.
  - stat_hits increments once per accepted read hit.
  - stat_misses increments once per accepted read miss.
  - Writes are not counted.
  - Counters wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- After reset release, read addr 0x000010 → miss. Back-side read of 0x000010 with lanes=0xFFFFFFFF; controller returns pattern P. fs_ack one cycle after bs_ack with fs_rdata=P.
- Repeat read 0x000010 → no back-side activity; fs_ack exactly 1 cycle after acceptance with P. Four back-to-back hit reads give four consecutive acks.
- Write 0x000010, lanes=0x00000001, wdata byte0=0xAB → back-side write carries the same addr/lanes/data. Subsequent read hit returns P with byte0=0xAB.
- Read 0x000110 (same index 0x10, different tag) → miss and refill. Then read 0x000010 → miss again (eviction).
- Write to uncached 0x000020 → back-side write and fs_ack. Next read 0x000020 still misses.
- Assert reset low during FILL_WAIT → no fs_ack. After release, read 0x000010 misses (valid bits cleared). With CACHE_STATS_EN defined, stat_misses=1, stat_hits=0.
